mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage 16-bit pipeline, directly upstream of write-back.

---
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_stage.sv | 72 +++++++
 tb/tb_mem_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, hazard controls and MEM/WB outputs of the memory stage.
interface mem_stage_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0]   alu_result;
    logic [DATA_W-1:0]   store_data;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write_en;
    logic [2:0]          dest;
    logic                wb_sel_alu;
    logic                hold;
    logic                flush;
    logic [2*DATA_W+4:0] mem_wb_out;
    logic                mem_busy;
    modport master (
        output alu_result, store_data, mem_read, mem_write, reg_write_en, dest, wb_sel_alu, hold, flush,
        input  mem_wb_out, mem_busy
    );
    modport slave (
        input  alu_result, store_data, mem_read, mem_write, reg_write_en, dest, wb_sel_alu, hold, flush,
        output mem_wb_out, mem_busy
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: data-memory access and MEM/WB register of the 16-bit pipeline.
// MEM_STAGE_WAIT_STATE_EN adds an IDLE/WAIT FSM so every memory access takes two cycles.
module mem_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int WB_W = 2 * DATA_W + 5;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ld;
    logic [WB_W-1:0]   wb_q;
    logic [WB_W-1:0]   wb_d;
    logic              we;
    logic              busy;
    assign addr = bus.alu_result[ADDR_W-1:0];
    assign ld   = bus.mem_read ? mem[addr] : '0;
`ifdef MEM_STAGE_WAIT_STATE_EN
    typedef enum logic {IDLE, WAIT} state_t;
    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (busy) rdata_q <= ld;
        end
    end
    // rdata_q is sampled before the store commits, so read+write returns the old word
    always_comb begin
        state_n = state;
        we      = 1'b0;
        busy    = 1'b0;
        wb_d    = wb_q;
        if (bus.flush) begin
            wb_d    = '0;
            state_n = IDLE;
        end else if (!bus.hold) begin
            if (state == WAIT) begin
                wb_d    = {rdata_q, bus.alu_result, bus.reg_write_en, bus.dest, bus.wb_sel_alu};
                we      = bus.mem_write;
                state_n = IDLE;
            end else if (bus.mem_read || bus.mem_write) begin
                wb_d    = '0;
                busy    = !rst;
                state_n = WAIT;
            end else begin
                wb_d = {ld, bus.alu_result, bus.reg_write_en, bus.dest, bus.wb_sel_alu};
            end
        end
    end
`else
    assign wb_d = bus.flush ? '0 : bus.hold ? wb_q : {ld, bus.alu_result, bus.reg_write_en, bus.dest, bus.wb_sel_alu};
    assign we   = bus.mem_write && !bus.flush && !bus.hold;
    assign busy = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_q <= '0;
        else wb_q <= wb_d;
    end
    always_ff @(posedge clk) begin
        if (we && !rst) mem[addr] <= bus.store_data;
    end
    assign bus.mem_wb_out = wb_q;
    assign bus.mem_busy   = busy;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, corner sequences and a randomized model check for mem_stage.
// Build with MEM_STAGE_WAIT_STATE_EN to exercise the wait-state sequence instead.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [15:0] m [256];
    logic [36:0] exp_wb = '0;
    mem_stage_if #(.DATA_W(16)) bus ();
    mem_stage #(.DATA_W(16), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] alu;
        logic [15:0] sd;
        logic        mr;
        logic        mw;
        logic        rwe;
        logic [2:0]  dest;
        logic        sel;
        logic        hold;
        logic        flush;
        logic [36:0] exp;
    } vec_t;
    vec_t tv [15];
    task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask
    task automatic drive(input logic [15:0] alu, input logic [15:0] sd, input logic mr, input logic mw,
                         input logic rwe, input logic [2:0] dst, input logic sel, input logic hl, input logic fl);
        bus.alu_result   = alu;
        bus.store_data   = sd;
        bus.mem_read     = mr;
        bus.mem_write    = mw;
        bus.reg_write_en = rwe;
        bus.dest         = dst;
        bus.wb_sel_alu   = sel;
        bus.hold         = hl;
        bus.flush        = fl;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // reference: flush gives a bubble, hold freezes, otherwise capture; stores only on capture
    task automatic step(input logic [15:0] alu, input logic [15:0] sd, input logic mr, input logic mw,
                        input logic rwe, input logic [2:0] dst, input logic sel, input logic hl, input logic fl);
        logic [7:0] a;
        a = alu[7:0];
        exp_wb = fl ? 37'h0 : hl ? exp_wb : {mr ? m[a] : 16'h0, alu, rwe, dst, sel};
        if (!fl && !hl && mw) m[a] = sd;
        drive(alu, sd, mr, mw, rwe, dst, sel, hl, fl);
        tick();
    endtask
    initial begin
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_out", bus.mem_wb_out, 37'h0);
        chk("reset_busy", {36'h0, bus.mem_busy}, 37'h0);
        #10 rst = 1'b0;
        tick();
`ifdef MEM_STAGE_WAIT_STATE_EN
        drive(16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("ws_busy_store", {36'h0, bus.mem_busy}, 37'h1);
        tick();
        chk("ws_store_bubble", bus.mem_wb_out, 37'h0);
        chk("ws_busy_wait", {36'h0, bus.mem_busy}, 37'h0);
        tick();
        chk("ws_store_done", bus.mem_wb_out, {16'h0, 16'h0012, 1'b0, 3'd0, 1'b1});
        drive(16'h0012, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #1 chk("ws_busy_load", {36'h0, bus.mem_busy}, 37'h1);
        tick();
        chk("ws_load_bubble", bus.mem_wb_out, 37'h0);
        tick();
        chk("ws_load_data", bus.mem_wb_out, {16'hBEEF, 16'h0012, 1'b1, 3'd3, 1'b0});
        drive(16'h0012, 16'h9999, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.flush = 1'b1;
        tick();
        chk("ws_flush_out", bus.mem_wb_out, 37'h0);
        drive(16'h0012, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #1 chk("ws_idle_after_flush", {36'h0, bus.mem_busy}, 37'h1);
        tick();
        tick();
        chk("ws_mem_unchanged", bus.mem_wb_out, {16'hBEEF, 16'h0012, 1'b1, 3'd3, 1'b0});
        #1 chk("ws_busy_pre_rst", {36'h0, bus.mem_busy}, 37'h1);
        rst = 1'b1;
        #1;
        chk("ws_rst_out", bus.mem_wb_out, 37'h0);
        chk("ws_rst_busy", {36'h0, bus.mem_busy}, 37'h0);
`else
        for (int i = 0; i < 256; i++) step(16'(i), 16'($urandom), 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        tv[0]  = '{16'h0020, 16'h1111, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, {16'h0000, 16'h0020, 1'b0, 3'd0, 1'b1}};
        tv[1]  = '{16'h0012, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, {16'h0000, 16'h0012, 1'b0, 3'd0, 1'b1}};
        tv[2]  = '{16'h0012, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, {16'hBEEF, 16'h0012, 1'b1, 3'd3, 1'b0}};
        tv[3]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, {16'h0000, 16'h1234, 1'b1, 3'd5, 1'b1}};
        tv[4]  = '{16'h0012, 16'hDEAD, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, {16'h0000, 16'h1234, 1'b1, 3'd5, 1'b1}};
        tv[5]  = tv[4];
        tv[6]  = tv[4];
        tv[7]  = '{16'h0020, 16'h5555, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 37'h0};
        tv[8]  = '{16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, {16'h1111, 16'h0020, 1'b1, 3'd1, 1'b0}};
        tv[9]  = '{16'h0012, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, {16'hBEEF, 16'h0012, 1'b1, 3'd2, 1'b0}};
        tv[10] = '{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 37'h0};
        tv[11] = '{16'h0030, 16'hAAAA, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, {16'h0000, 16'h0030, 1'b0, 3'd0, 1'b1}};
        tv[12] = '{16'h0030, 16'h7777, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, {16'hAAAA, 16'h0030, 1'b1, 3'd4, 1'b0}};
        tv[13] = '{16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, {16'h7777, 16'h0030, 1'b1, 3'd4, 1'b0}};
        tv[14] = '{16'hFF12, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, {16'hBEEF, 16'hFF12, 1'b1, 3'd6, 1'b0}};
        for (int i = 0; i < 15; i++) begin
            step(tv[i].alu, tv[i].sd, tv[i].mr, tv[i].mw, tv[i].rwe, tv[i].dest, tv[i].sel, tv[i].hold, tv[i].flush);
            chk($sformatf("vec%0d", i), bus.mem_wb_out, tv[i].exp);
            chk($sformatf("vec%0d_busy", i), {36'h0, bus.mem_busy}, 37'h0);
        end
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_out", bus.mem_wb_out, 37'h0);
        chk("midrun_rst_busy", {36'h0, bus.mem_busy}, 37'h0);
        tick();
        rst = 1'b0;
        exp_wb = '0;
        tick();
        for (int i = 0; i < 500; i++) begin
            logic [15:0] alu;
            alu = (16'($urandom) & 16'hFF00) | 16'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 255));
            step(alu, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            chk($sformatf("rand%0d", i), bus.mem_wb_out, exp_wb);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
